// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Holds the controller state encoding and the counter width helper.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } mult_state_t;

    // Bits needed to hold the values 0 .. v-1.
    function automatic int width_for(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_ctrl_counter.sv
// Loadable up/down counter used as the multiplier iteration counter.
// Ports: clk, rst (async, active-high), load/data_in, en/up_down, data_out.
module shift_add_ctrl_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         up_down,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= data_in;
        end else if (en) begin
            if (up_down) begin
                data_out <= data_out + 1'b1;
            end else begin
                data_out <= data_out - 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_add_ctrl.sv
// Control FSM for the shift-add multiplier: load, per-bit add, shift, done.
// Ports: clk, rst, start, q0, abort (MULT_CTRL_ABORT_EN only),
//   load_regs, add_en, shift_en, busy, done, iter (remaining iterations).
module shift_add_ctrl
    import mult_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = width_for(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          q0,
`ifdef MULT_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          load_regs,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    mult_state_t state;
    mult_state_t state_n;
    logic        abort_hit;
    logic        cnt_load;
    logic [CW-1:0] cnt_din;

`ifdef MULT_CTRL_ABORT_EN
    // IDLE has nothing to cancel and DONE has already committed the pulse.
    assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load_regs = 1'b0;
        add_en    = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = LOAD;
            end
            LOAD: begin
                load_regs = 1'b1;
                state_n   = CHECK;
            end
            CHECK: begin
                state_n = q0 ? ADD : SHIFT;
            end
            ADD: begin
                add_en  = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                state_n  = (iter == CW'(1)) ? DONE : CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort_hit) state_n = IDLE;
    end

    // Abort reuses the counter load path to clear the count.
    assign cnt_load = load_regs || abort_hit;
    assign cnt_din  = abort_hit ? '0 : CW'(N);

    shift_add_ctrl_counter #(
        .N(CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (shift_en),
        .up_down (1'b0),
        .data_in (cnt_din),
        .data_out(iter)
    );

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Self-checking bench for shift_add_ctrl with a behavioural datapath.
// Covers reset, timing vs popcount, products, start handling, abort option.
module tb_shift_add_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q0;
    logic          abort;
    logic          load_regs;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    int nvec = 0;
    int nmis = 0;

    logic [N-1:0] a_in, b_in;
    logic [N-1:0] m, acc, q;
    logic         c;

    always #5 clk = ~clk;

    shift_add_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q0       (q0),
`ifdef MULT_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .load_regs(load_regs),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .iter     (iter)
    );

    assign q0 = q[0];
    always @(posedge clk) begin
        if (load_regs) begin
            m   <= a_in;
            q   <= b_in;
            acc <= '0;
            c   <= 1'b0;
        end else if (add_en) begin
            {c, acc} <= {1'b0, acc} + {1'b0, m};
        end else if (shift_en) begin
            {c, acc, q} <= {1'b0, c, acc, q[N-1:1]};
        end
    end

    `define CHK(tag, o, e) begin \
        nvec++; \
        assert ((o) === (e)) else begin \
            nmis++; \
            $error("FAIL %s obs=%0h exp=%0h", tag, (o), (e)); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        `CHK({tag, "_load"}, load_regs, 1'b0)
        `CHK({tag, "_add"}, add_en, 1'b0)
        `CHK({tag, "_shift"}, shift_en, 1'b0)
        `CHK({tag, "_busy"}, busy, 1'b0)
        `CHK({tag, "_done"}, done, 1'b0)
        `CHK({tag, "_iter"}, iter, 4'd0)
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int rst_at, input bit noisy);
        int cyc, shifts, adds, loads, dcyc, exp_done;
        logic [2*N-1:0] prod;
        a_in = a;
        b_in = b;
        `CHK("idle_busy", busy, 1'b0)
        start = 1'b1;
        exp_done = 2 + 2 * N + $countones(b);
        shifts = 0; adds = 0; loads = 0; dcyc = -1; cyc = 0;
        while (cyc < 40 && dcyc < 0) begin
            tick();
            cyc++;
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_quiet("rst_mid");
                tick();
                rst = 1'b0;
                return;
            end
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            `CHK("onehot", $onehot0({load_regs, add_en, shift_en}), 1'b1)
            `CHK("iter", iter, CW'((cyc < 2) ? 0 : N - shifts))
            if (cyc == 1) `CHK("load_c1", load_regs, 1'b1)
            if (!done) `CHK("busy", busy, 1'b1)
            shifts += int'(shift_en);
            adds   += int'(add_en);
            loads  += int'(load_regs);
            if (done) dcyc = cyc;
        end
        nvec++;
        if (dcyc < 0) begin
            nmis++;
            $error("FAIL timeout: no done within %0d cycles", cyc);
        end
        `CHK("done_cycle", dcyc, exp_done)
        `CHK("shifts", shifts, N)
        `CHK("adds", adds, $countones(b))
        `CHK("loads", loads, 1)
        prod = 16'(a) * 16'(b);
        `CHK("product", {acc, q}, prod)
        tick();
        start = 1'b0;
        check_quiet("after");
    endtask

    initial begin
        int lc[$];
        int cyc;
        logic [N-1:0] b;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        a_in = '0;
        b_in = '0;
        #12;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || load_regs !== 1'b0 ||
            add_en !== 1'b0 || shift_en !== 1'b0 || iter !== '0) begin
            nmis++;
            $error("FAIL reset state: busy=%b done=%b iter=%0h",
                   busy, done, iter);
        end
        check_quiet("reset");
        tick();
        rst = 1'b0;
        tick();
        check_quiet("rel");

        run_op(8'h12, 8'h00, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h03, 8'hA5, 0, 1'b0);
        run_op(8'h5C, 8'h3B, 7, 1'b0);
        run_op(8'h03, 8'hA5, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom), 8'($urandom), 0, 1'b1);
        end

        b = 8'($urandom);
        a_in = 8'h77;
        b_in = b;
        start = 1'b1;
        cyc = 0;
        while (cyc < 120 && lc.size() < 3) begin
            tick();
            cyc++;
            if (load_regs) lc.push_back(cyc);
        end
        `CHK("held_loads", lc.size(), 3)
        if (lc.size() == 3) begin
            `CHK("held_gap1", lc[1] - lc[0], 3 + 2 * N + $countones(b))
            `CHK("held_gap2", lc[2] - lc[1], 3 + 2 * N + $countones(b))
        end
        start = 1'b0;
        cyc = 0;
        while (cyc < 40 && busy) begin
            tick();
            cyc++;
        end
        nvec++;
        if (busy) begin
            nmis++;
            $error("FAIL timeout: still busy after %0d cycles", cyc);
        end
        tick();
        check_quiet("held_end");

`ifdef MULT_CTRL_ABORT_EN
        a_in = 8'h21;
        b_in = 8'hC3;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abort");
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cyc += int'(done);
        end
        `CHK("abort_nodone", cyc, 0)
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abort_idle");

        b_in = 8'h0F;
        start = 1'b1;
        cyc = 0;
        while (cyc < 40 && !done) begin
            tick();
            start = 1'b0;
            cyc++;
        end
        `CHK("abdone_cyc", cyc, 2 + 2 * N + 4)
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abdone_after");
        run_op(8'h9D, 8'h6E, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/shift_add_ctrl.md
# shift_add_ctrl

Control FSM for the shift-add multiplier. It sequences the multiplicand/multiplier/accumulator datapath through load, per-bit conditional add, and shift steps, and tracks iterations with an internal down-counter. It also provides a start/busy/done handshake to the enclosing system. It sits between the system-level requester and the multiplier datapath and owns every datapath control strobe.

## Interface
- N, 8, operand width in bits (number of iterations); N ≥ 2
- CW, $clog2(N+1), iteration counter width (localparam, not overridable)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a multiplication; sampled only in IDLE
- q0  in  1  current multiplier LSB from datapath
- abort  in  1  cancel operation (present only with MULT_CTRL_ABORT_EN)
- load_regs  out  1  load operands, clear accumulator
- add_en  out  1  accumulator ← accumulator + multiplicand
- shift_en  out  1  shift accumulator/multiplier pair right by one
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: product valid in datapath
- iter  out  CW  remaining iterations (counter value)

## Operation
- States: IDLE, LOAD, CHECK, ADD, SHIFT, DONE.
- IDLE: all strobes 0. If start=1, go to LOAD. Otherwise stay in IDLE.
- LOAD: load_regs=1, counter loaded with N. Always go to CHECK.
- CHECK: no strobes. If q0=1, go to ADD. If q0=0, go to SHIFT.
- ADD: add_en=1. Always go to SHIFT.
- SHIFT: shift_en=1, counter decrement enabled.
  - If iter==1 (last iteration), go to DONE.
  - Otherwise go to CHECK.
- DONE: done=1. Always go to IDLE.
- Exactly one of load_regs/add_en/shift_en is high in any cycle, or none is.
- All outputs are Moore outputs, decoded from the state register and the counter.
- start while busy=1 (including DONE) is ignored, not queued.
- Counter arithmetic is unsigned, width CW. Decrement happens only in SHIFT, so iter never wraps below 0.
- rst at any time: state=IDLE, counter=0, all outputs 0 asynchronously. The datapath is left as-is, and its contents are don't-care.

## Timing
- Reset values: load_regs=0, add_en=0, shift_en=0, busy=0, done=0, iter=0.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Cycle 1: LOAD. Cycle 2: first CHECK.
- Each zero multiplier bit takes 2 cycles (CHECK, SHIFT). Each one bit takes 3 cycles (CHECK, ADD, SHIFT).
- done is asserted in cycle 2 + 2N + k, where k is the popcount of the multiplier.
- N=8: done at cycle 18 for k=0, and at cycle 26 for k=8.
- iter reads N from cycle 2 and decrements by one after each SHIFT edge. It reads 0 in DONE and stays 0 in IDLE until the next LOAD.
- Back-to-back: the earliest next start is sampled the cycle after DONE (IDLE).
- q0 is sampled only in CHECK. Its value in other states is ignored.

## Configuration
- MULT_CTRL_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in any state other than IDLE or DONE forces the next state to IDLE. No done pulse is issued, and the counter is cleared to 0 on that edge.
  - abort in IDLE has no effect. abort in DONE does not suppress the done pulse already in progress.
  - abort takes priority over start only in non-IDLE states.
- MULT_CTRL_ABORT_EN undefined: the abort port is absent, and every started operation runs to DONE.

## Structure
- Shared package mult_pkg holds:
  - typedef enum logic [2:0] mult_state_t (IDLE, LOAD, CHECK, ADD, SHIFT, DONE)
  - the width helper used to derive CW
- Sub-module: one instance of the team's existing counter block with parameter N=CW:
  - load driven by LOAD, data_in=N
  - en driven by SHIFT, with up_down=0
  - data_out drives iter
- Abort clearing uses that instance's load with data_in=0.
- The FSM itself is a single state register plus combinational next-state and output decode.

## Test plan
- Reset mid-operation: start, run to cycle 7, assert rst → all outputs 0 immediately, state IDLE. A new start after release gives done at the nominal cycle.
- N=8, q0 held 0 (multiplier 0x00) → shift_en high 8 times, add_en never high, done at cycle 18, iter sequence 8→0.
- N=8, q0 held 1 (multiplier 0xFF) → 8 ADD/SHIFT pairs, done at cycle 26. With the datapath model, A=0xFF gives product 0xFE01.
- N=8, multiplier 0xA5 driven through the datapath model (k=4) → done at cycle 22, product for A=0x03 equals 0x01EF, strobes mutually exclusive every cycle.
- start held high continuously → exactly one operation per LOAD, with a new LOAD on the cycle after IDLE re-entry. start pulses during busy produce no extra LOAD.
- MULT_CTRL_ABORT_EN: abort at cycle 5 → busy=0 at cycle 6, done never pulses, iter=0. abort in DONE → done still pulses once.
